// File: rtl/mac_seq_ctrl.sv
// Operand-read / MAC-enable sequencer for one PE MAC lane: streams NMAX reads per
// output channel, captures the MAC result and hands it downstream over valid/ready.
module mac_seq_ctrl #(
  parameter int DW   = 32,
  parameter int NMAX = 64,
  parameter int AW   = 10,
  parameter int OCW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  data_base,
  input  logic [AW-1:0]  wgt_base,
  input  logic [OCW-1:0] num_oc,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           dbuf_re,
  output logic [AW-1:0]  dbuf_addr,
  output logic           wbuf_re,
  output logic [AW-1:0]  wbuf_addr,
  output logic           mac_ena,
  input  logic           mac_cnt_c,
  input  logic [DW-1:0]  mac_result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [DW-1:0]  res_data,
  output logic [OCW-1:0] res_oc
);

  localparam int KW = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NMAX - 1);
  localparam logic [AW-1:0] WSTEP = AW'(NMAX);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT, S_FIN} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [OCW-1:0] oc_q, oc_d;
  logic [OCW-1:0] noc_q, noc_d;
  logic [AW-1:0]  dbase_q, dbase_d;
  logic [AW-1:0]  wrow_q, wrow_d;
  logic [1:0]     tmo_q, tmo_d;
  logic           re_q, re_d;
  logic [AW-1:0]  daddr_q, daddr_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic           mac_ena_q, mac_ena_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           rv_q, rv_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [OCW-1:0] roc_q, roc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      oc_q      <= '0;
      noc_q     <= '0;
      dbase_q   <= '0;
      wrow_q    <= '0;
      tmo_q     <= '0;
      re_q      <= 1'b0;
      daddr_q   <= '0;
      waddr_q   <= '0;
      mac_ena_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rv_q      <= 1'b0;
      rdata_q   <= '0;
      roc_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      oc_q      <= oc_d;
      noc_q     <= noc_d;
      dbase_q   <= dbase_d;
      wrow_q    <= wrow_d;
      tmo_q     <= tmo_d;
      re_q      <= re_d;
      daddr_q   <= daddr_d;
      waddr_q   <= waddr_d;
      mac_ena_q <= mac_ena_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rv_q      <= rv_d;
      rdata_q   <= rdata_d;
      roc_q     <= roc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    oc_d    = oc_q;
    noc_d   = noc_q;
    dbase_d = dbase_q;
    wrow_d  = wrow_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    roc_d   = roc_q;
    // Read strobe/address are registered from the current LOAD state, so the
    // bus lags the state by one cycle and mac_ena lags the bus by one more.
    re_d      = (state_q == S_LOAD);
    daddr_d   = re_d ? dbase_q + AW'(k_q) : '0;
    waddr_d   = re_d ? wrow_q + AW'(k_q) : '0;
    mac_ena_d = re_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dbase_d = data_base;
          wrow_d  = wgt_base;
          noc_d   = num_oc;
          err_d   = 1'b0;
          oc_d    = '0;
          k_d     = '0;
          tmo_d   = '0;
          state_d = (num_oc == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (k_q == KLAST) begin
          k_d     = '0;
          state_d = S_WAIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_WAIT: begin
        if (mac_cnt_c) begin
          rdata_d = mac_result;
          roc_d   = oc_q;
          rv_d    = 1'b1;
          state_d = S_OUT;
        end else if (!(re_q || mac_ena_q)) begin
          // Timeout window opens only once the operand pipeline has drained.
          if (tmo_q == 2'd3) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            tmo_d = tmo_q + 2'd1;
          end
        end
      end
      S_OUT: begin
        if (rv_q && res_ready) begin
          rv_d = 1'b0;
          if (oc_q == noc_q - OCW'(1)) begin
            state_d = S_FIN;
          end else begin
            oc_d    = oc_q + OCW'(1);
            wrow_d  = wrow_q + WSTEP;
            k_d     = '0;
            tmo_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_OUT);
    done_d = (state_d == S_FIN);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbuf_re   = re_q;
  assign wbuf_re   = re_q;
  assign dbuf_addr = daddr_q;
  assign wbuf_addr = waddr_q;
  assign mac_ena   = mac_ena_q;
  assign res_valid = rv_q;
  assign res_data  = rdata_q;
  assign res_oc    = roc_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: buffer + MAC models, result scoreboard,
// plus a narrow-address instance for the wrap case.
module tb_mac_seq_ctrl;
  localparam int DW = 32, NMAX = 4, AW = 10, OCW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [AW-1:0]  data_base = '0, wgt_base = '0;
  logic [OCW-1:0] num_oc = '0;
  logic           busy, done, err, dbuf_re, wbuf_re, mac_ena, res_valid;
  logic [AW-1:0]  dbuf_addr, wbuf_addr;
  logic           mac_cnt_c;
  logic [DW-1:0]  mac_result, res_data;
  logic           res_ready = 1'b1;
  logic [OCW-1:0] res_oc;

  mac_seq_ctrl #(.DW(DW), .NMAX(NMAX), .AW(AW), .OCW(OCW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_base(data_base),
    .wgt_base(wgt_base), .num_oc(num_oc), .busy(busy), .done(done), .err(err),
    .dbuf_re(dbuf_re), .dbuf_addr(dbuf_addr), .wbuf_re(wbuf_re),
    .wbuf_addr(wbuf_addr), .mac_ena(mac_ena), .mac_cnt_c(mac_cnt_c),
    .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_oc(res_oc));

  // Narrow-address instance; its MAC never completes, so each job times out.
  logic           start_w = 1'b0;
  logic [3:0]     data_base_w = '0, wgt_base_w = '0;
  logic [OCW-1:0] num_oc_w = '0;
  logic           busy_w, done_w, err_w, dbuf_re_w, wbuf_re_w, mac_ena_w, res_valid_w;
  logic [3:0]     dbuf_addr_w, wbuf_addr_w;
  logic           mac_cnt_c_w = 1'b0;
  logic [DW-1:0]  mac_result_w = '0;
  logic           res_ready_w = 1'b1;
  logic [DW-1:0]  res_data_w;
  logic [OCW-1:0] res_oc_w;

  mac_seq_ctrl #(.DW(DW), .NMAX(NMAX), .AW(4), .OCW(OCW)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .data_base(data_base_w),
    .wgt_base(wgt_base_w), .num_oc(num_oc_w), .busy(busy_w), .done(done_w), .err(err_w),
    .dbuf_re(dbuf_re_w), .dbuf_addr(dbuf_addr_w), .wbuf_re(wbuf_re_w),
    .wbuf_addr(wbuf_addr_w), .mac_ena(mac_ena_w), .mac_cnt_c(mac_cnt_c_w),
    .mac_result(mac_result_w), .res_valid(res_valid_w), .res_ready(res_ready_w),
    .res_data(res_data_w), .res_oc(res_oc_w));

  int checks = 0, failures = 0, cyc = 0, xfers = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dval(input logic [AW-1:0] a);
    return 32'(a) * 32'd7 + 32'd3;
  endfunction
  function automatic logic [31:0] wval(input logic [AW-1:0] a);
    return 32'(a) * 32'd5 + 32'd1;
  endfunction

  // Synchronous operand buffers and a counting MAC that raises cnt_c the cycle
  // after its NMAX-th enable (suppressed when mac_hang is set).
  logic [DW-1:0] dq, wq, acc;
  int mcnt;
  logic mac_hang = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq <= '0; wq <= '0; acc <= '0; mcnt <= 0; mac_cnt_c <= 1'b0; mac_result <= '0;
    end else begin
      if (dbuf_re) dq <= dval(dbuf_addr);
      if (wbuf_re) wq <= wval(wbuf_addr);
      mac_cnt_c <= 1'b0;
      if (mac_ena) begin
        if (mcnt == NMAX - 1) begin
          mcnt <= 0; acc <= '0;
          mac_result <= acc + dq * wq;
          mac_cnt_c <= !mac_hang;
        end else begin
          mcnt <= mcnt + 1; acc <= acc + dq * wq;
        end
      end
    end
  end

  typedef struct { logic [OCW-1:0] oc; logic [DW-1:0] data; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] exp_sum(input logic [AW-1:0] db, input logic [AW-1:0] wr);
    logic [DW-1:0] s = '0;
    for (int k = 0; k < NMAX; k++) s += dval(db + AW'(k)) * wval(wr + AW'(k));
    return s;
  endfunction

  task automatic push_exp(input int oc, input logic [AW-1:0] db, input logic [AW-1:0] wr);
    exp_t e;
    e.oc = OCW'(oc);
    e.data = exp_sum(db, wr);
    sbq.push_back(e);
  endtask

  // Transfer monitor: samples after the bench has driven res_ready for this cycle.
  always begin
    @(negedge clk); #2;
    if (rst_n && res_valid && res_ready) begin
      if (sbq.size() == 0) chk("sb_unexpected_xfer", 64'(sbq.size()), 64'd1);
      else begin
        mon_e = sbq.pop_front();
        chk("res_oc", 64'(res_oc), 64'(mon_e.oc));
        chk("res_data", 64'(res_data), 64'(mon_e.data));
      end
      xfers <= xfers + 1;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return dbuf_re;
      1: return res_valid;
      2: return done;
      default: return done_w;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w);
    int n = 0;
    while (!sel(w) && n < 40) begin step(); n++; end
    chk(tag, 64'(sel(w)), 64'd1);
  endtask

  // Checks one channel's read burst and the one-cycle-delayed mac_ena window.
  task automatic run_load(input string tag, input logic [AW-1:0] db, input logic [AW-1:0] wr,
                          output int c0);
    wait_for({tag, "_re_start"}, 0);
    c0 = cyc;
    for (int i = 0; i < NMAX; i++) begin
      chk({tag, "_daddr"}, 64'(dbuf_addr), 64'(AW'(db + AW'(i))));
      chk({tag, "_waddr"}, 64'(wbuf_addr), 64'(AW'(wr + AW'(i))));
      chk({tag, "_wre"}, 64'(wbuf_re), 64'd1);
      chk({tag, "_mac_ena"}, 64'(mac_ena), 64'(i != 0));
      step();
    end
    chk({tag, "_re_end"}, 64'(dbuf_re), 64'd0);
    chk({tag, "_mac_ena_last"}, 64'(mac_ena), 64'd1);
    step();
    chk({tag, "_mac_ena_off"}, 64'(mac_ena), 64'd0);
  endtask

  initial begin
    int c0, c1, x0, n, cl;
    logic rv_seen, any_rd;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_re", 64'(dbuf_re), 64'd0);
    chk("rst_mac_ena", 64'(mac_ena), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_addr", 64'({dbuf_addr, wbuf_addr}), 64'd0);
    rst_n = 1'b1;
    step();

    // Address wrap on the 4-bit instance.
    start_w = 1'b1; data_base_w = 4'hE; wgt_base_w = 4'h3; num_oc_w = 8'd1;
    step();
    start_w = 1'b0;
    n = 0;
    while (!dbuf_re_w && n < 20) begin step(); n++; end
    for (int i = 0; i < NMAX; i++) begin
      logic [3:0] ed, ew;
      ed = 4'hE + 4'(i);
      ew = 4'h3 + 4'(i);
      chk("wrap_re", 64'(dbuf_re_w), 64'd1);
      chk("wrap_daddr", 64'(dbuf_addr_w), 64'(ed));
      chk("wrap_waddr", 64'(wbuf_addr_w), 64'(ew));
      step();
    end
    wait_for("wrap_done", 3);
    chk("wrap_err", 64'(err_w), 64'd1);

    // Single channel.
    x0 = xfers;
    push_exp(0, 10'h10, 10'h20);
    start = 1'b1; data_base = 10'h10; wgt_base = 10'h20; num_oc = 8'd1; res_ready = 1'b1;
    step();
    start = 1'b0; data_base = 10'h3F0; wgt_base = 10'h155; num_oc = 8'd7;
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    chk("t1_no_re_yet", 64'(dbuf_re), 64'd0);
    run_load("t1", 10'h10, 10'h20, c0);
    wait_for("t1_rv", 1);
    chk("t1_read_to_valid", 64'(cyc - c0), 64'(NMAX + 2));
    wait_for("t1_done", 2);
    chk("t1_done_busy", 64'(busy), 64'd0);
    chk("t1_err", 64'(err), 64'd0);
    step();
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_xfers", 64'(xfers - x0), 64'd1);

    // Three channels, backpressure on oc=1, ignored start while busy.
    x0 = xfers;
    push_exp(0, 10'h10, 10'h20);
    push_exp(1, 10'h10, 10'h24);
    push_exp(2, 10'h10, 10'h28);
    start = 1'b1; data_base = 10'h10; wgt_base = 10'h20; num_oc = 8'd3;
    step();
    start = 1'b0;
    run_load("t2oc0", 10'h10, 10'h20, c0);
    start = 1'b1; data_base = 10'h100; num_oc = 8'd0;
    step();
    start = 1'b0;
    wait_for("t2_rv0", 1);
    run_load("t2oc1", 10'h10, 10'h24, c1);
    chk("t2_load_spacing", 64'(c1 - c0), 64'(NMAX + 4));
    res_ready = 1'b0;
    wait_for("t2_rv1", 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 64'(res_valid), 64'd1);
      chk("t2_stall_data", 64'(res_data), 64'(exp_sum(10'h10, 10'h24)));
      chk("t2_stall_oc", 64'(res_oc), 64'd1);
      step();
    end
    res_ready = 1'b1;
    run_load("t2oc2", 10'h10, 10'h28, c0);
    wait_for("t2_done", 2);
    step();
    chk("t2_xfers", 64'(xfers - x0), 64'd3);
    chk("t2_sb_empty", 64'(sbq.size()), 64'd0);

    // MAC never completes: timeout, sticky err.
    mac_hang = 1'b1;
    start = 1'b1; data_base = 10'h10; wgt_base = 10'h20; num_oc = 8'd2;
    step();
    start = 1'b0;
    run_load("t3", 10'h10, 10'h20, c0);
    cl = cyc - 1;
    rv_seen = 1'b0; n = 0;
    while (!done && n < 20) begin
      if (res_valid) rv_seen = 1'b1;
      step(); n++;
    end
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_done_latency", 64'(cyc - cl), 64'd5);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_no_rv", 64'(rv_seen), 64'd0);
    step(); step();
    chk("t3_err_sticky", 64'(err), 64'd1);
    chk("t3_idle_busy", 64'(busy), 64'd0);

    // num_oc=0 job also clears err.
    mac_hang = 1'b0;
    start = 1'b1; num_oc = 8'd0;
    step();
    start = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_err_clr", 64'(err), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    any_rd = dbuf_re | wbuf_re | mac_ena;
    step();
    any_rd = any_rd | dbuf_re | wbuf_re | mac_ena;
    chk("t4_done_once", 64'(done), 64'd0);
    chk("t4_no_reads", 64'(any_rd), 64'd0);

    // Async reset mid-LOAD on oc=1, then a clean job.
    push_exp(0, 10'h10, 10'h20);
    start = 1'b1; data_base = 10'h10; wgt_base = 10'h20; num_oc = 8'd2;
    step();
    start = 1'b0;
    run_load("t5oc0", 10'h10, 10'h20, c0);
    wait_for("t5_rv0", 1);
    wait_for("t5_re1", 0);
    step(); step();
    chk("t5_pre_mac_ena", 64'(mac_ena), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mac_ena", 64'(mac_ena), 64'd0);
    chk("t5_rst_re", 64'({dbuf_re, wbuf_re}), 64'd0);
    chk("t5_rst_rv", 64'(res_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    step(); step();
    chk("t5_rst_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    step();
    chk("t5_sb_after_rst", 64'(sbq.size()), 64'd0);
    sbq.delete();
    x0 = xfers;
    push_exp(0, 10'h30, 10'h40);
    start = 1'b1; data_base = 10'h30; wgt_base = 10'h40; num_oc = 8'd1;
    step();
    start = 1'b0;
    run_load("t5new", 10'h30, 10'h40, c0);
    wait_for("t5_done", 2);
    step();
    chk("t5_xfers", 64'(xfers - x0), 64'd1);
    chk("t5_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=20000", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for one PE MAC lane.
- Takes a job descriptor of data base, weight base and output-channel count.
- For each output channel it streams NMAX operand reads from the data and weight buffers and drives the MAC enable aligned to the returning read data.
- It captures the MAC result when the MAC signals completion and hands each result downstream over a valid/ready interface.
- Sits between the layer controller and the PE MAC and its operand buffers.

Parameters:
DW, 32, data/weight/result width (matches MAC)
NMAX, 64, dot-product length per output channel (matches MAC)
AW, 10, operand buffer address width
OCW, 8, output-channel count width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle job start; sampled only in IDLE
data_base  in  AW  data buffer start address
wgt_base  in  AW  weight buffer start address
num_oc  in  OCW  number of output channels (0 allowed)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end
err  out  1  sticky timeout flag; cleared by the next accepted start
dbuf_re  out  1  data buffer read enable (synchronous buffer, 1-cycle read latency)
dbuf_addr  out  AW  data buffer read address
wbuf_re  out  1  weight buffer read enable
wbuf_addr  out  AW  weight buffer read address
mac_ena  out  1  MAC accumulate enable
mac_cnt_c  in  1  MAC completion flag
mac_result  in  DW  MAC result; valid only while mac_cnt_c is high
res_valid  out  1  result valid
res_ready  in  1  downstream ready
res_data  out  DW  captured result
res_oc  out  OCW  output-channel index of res_data

Behaviour:
- Reset (async, active-low): all state registers and outputs are 0; state = IDLE.
- Reset mid-job drops mac_ena, re and res_valid immediately; no done pulse follows.
- All outputs are registered.
- States and transitions:
  - IDLE: on start, latch the descriptors, clear err, set oc=0, k=0. If num_oc==0 go to FIN; otherwise go to LOAD.
  - LOAD: assert dbuf_re and wbuf_re for exactly NMAX consecutive cycles, k=0..NMAX-1.
    - dbuf_addr = data_base+k.
    - wbuf_addr = wgt_base+oc*NMAX+k.
    - Both addresses are truncated to AW bits, so they wrap modulo 2^AW.
    - After k=NMAX-1, go to WAIT.
  - Throughout LOAD/WAIT, mac_ena is re delayed by one cycle. It is therefore high for exactly NMAX consecutive cycles, each aligned with the buffer read data.
  - WAIT: when mac_cnt_c is high, capture mac_result into res_data and oc into res_oc, set res_valid, and go to OUT.
    - Expected: mac_cnt_c arrives in the first cycle after the last mac_ena cycle.
    - If it is not seen within 4 cycles after mac_ena falls, set err and go to FIN, abandoning the remaining channels.
  - OUT: hold res_valid, res_data and res_oc stable until res_valid&&res_ready.
    - On transfer, clear res_valid.
    - If oc==num_oc-1 go to FIN; otherwise oc++, k=0, go to LOAD.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- start outside IDLE is ignored.
- Changes to the descriptor inputs after acceptance have no effect.
- mac_cnt_c outside WAIT is ignored and has no capture side effect.
- res_ready while res_valid=0 is ignored.
- mac_ena is never high in OUT. The MAC counter therefore restarts from 0 for each channel.
- Per-channel latency:
  - First read to res_valid: NMAX+2 cycles.
  - With res_ready held high, consecutive LOAD entries are NMAX+4 cycles apart.
- busy=1 in LOAD, WAIT and OUT; busy=0 in IDLE and FIN.

Test Plan:
- Single channel: NMAX=4, data_base=0x10, wgt_base=0x20, num_oc=1, res_ready=1.
  - Required: dbuf_addr 0x10..0x13 and wbuf_addr 0x20..0x23 on consecutive cycles.
  - Required: mac_ena high 4 cycles, delayed one cycle from re.
  - Required: res_data equals the modelled MAC sum, res_oc=0, then a done pulse.
- Multi-channel with backpressure: num_oc=3; res_ready low for 5 cycles on oc=1.
  - Required: res_valid/res_data/res_oc held stable throughout the stall.
  - Required: wbuf_addr bases 0x20, 0x24, 0x28.
  - Required: exactly 3 transfers, oc 0,1,2, then done.
- Edge cases: num_oc=0 gives done exactly one cycle after start, with no re and no mac_ena. A start pulse while busy is ignored.
- Address wrap: AW=4, data_base=0xE, NMAX=4.
  - Required: dbuf_addr sequence E,F,0,1.
- Timeout: the MAC model never asserts mac_cnt_c.
  - Required: err=1 and done pulse 5 cycles after mac_ena falls, no res_valid.
  - Required: the next start clears err.
- Async reset: assert rst_n low mid-LOAD on oc=1.
  - Required: mac_ena, re, res_valid, busy and done go to 0 immediately.
  - Required: after release, IDLE accepts a new job and completes normally.
